// File: rtl/pu_cfg_pkg.sv
// pu_cfg_pkg
//   Shared definitions for the PU layer controllers:
//   - FSM state encodings (kept as plain constants so legacy decoders that
//     look at the raw 3-bit state keep working).
//   - Default config field widths, bit offsets and CFG_WIDTH derivation.
//   - Unpack helper for a default-width config word.
//   Config word packing, MSB to LSB:
//     {max_threads, pad, skip, endrow_iw, ic, ih, iw, oc, kh, kw}
package pu_cfg_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam int unsigned PU_LAYER_PARAM_WIDTH = 10;
  localparam int unsigned PU_PAD_WIDTH         = 3;
  localparam int unsigned PU_TID_WIDTH         = 16;
  localparam int unsigned PU_CFG_ADDR_W        = 4;

  // Index of each minus-one-encoded dimension field, counted from the LSB.
  localparam int unsigned FLD_KW         = 0;
  localparam int unsigned FLD_KH         = 1;
  localparam int unsigned FLD_OC         = 2;
  localparam int unsigned FLD_IW         = 3;
  localparam int unsigned FLD_IH         = 4;
  localparam int unsigned FLD_IC         = 5;
  localparam int unsigned FLD_ENDROW_IW  = 6;
  localparam int unsigned NUM_DIM_FIELDS = 7;

  function automatic int unsigned cfg_width(input int unsigned lpw,
                                            input int unsigned padw,
                                            input int unsigned tidw);
    return tidw + padw + 1 + NUM_DIM_FIELDS * lpw;
  endfunction

  function automatic int unsigned dim_lsb(input int unsigned fld, input int unsigned lpw);
    return fld * lpw;
  endfunction

  function automatic int unsigned skip_lsb(input int unsigned lpw);
    return NUM_DIM_FIELDS * lpw;
  endfunction

  function automatic int unsigned pad_lsb(input int unsigned lpw);
    return NUM_DIM_FIELDS * lpw + 1;
  endfunction

  function automatic int unsigned tid_lsb(input int unsigned lpw, input int unsigned padw);
    return NUM_DIM_FIELDS * lpw + 1 + padw;
  endfunction

  localparam int unsigned PU_CFG_WIDTH =
    cfg_width(PU_LAYER_PARAM_WIDTH, PU_PAD_WIDTH, PU_TID_WIDTH);

  typedef struct packed {
    logic [PU_TID_WIDTH-1:0]         max_threads;
    logic [PU_PAD_WIDTH-1:0]         pad;
    logic                            skip;
    logic [PU_LAYER_PARAM_WIDTH-1:0] endrow_iw;
    logic [PU_LAYER_PARAM_WIDTH-1:0] ic;
    logic [PU_LAYER_PARAM_WIDTH-1:0] ih;
    logic [PU_LAYER_PARAM_WIDTH-1:0] iw;
    logic [PU_LAYER_PARAM_WIDTH-1:0] oc;
    logic [PU_LAYER_PARAM_WIDTH-1:0] kh;
    logic [PU_LAYER_PARAM_WIDTH-1:0] kw;
  } pu_cfg_t;

  function automatic pu_cfg_t unpack_cfg(input logic [PU_CFG_WIDTH-1:0] word);
    return pu_cfg_t'(word);
  endfunction

endpackage

// File: rtl/pu_loop_counter.sv
// pu_loop_counter
//   Nested (oc, ic, row) counter, row innermost. Advances on i_en, holds at
//   the final tuple instead of wrapping, and restarts from zero on i_clr.
//   Ports:
//     i_clk, i_rst_n           clock, synchronous active-low reset
//     i_clr                    zero all counters
//     i_en                     advance one step
//     i_lim_row/ic/oc          inclusive upper limits
//     o_row/o_ic/o_oc          current indices
//     o_last_ic                o_ic at its limit
//     o_last                   all three indices at their limits
module pu_loop_counter
  #(
    parameter int unsigned WIDTH = 10
  )
  (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_lim_row,
    input  logic [WIDTH-1:0] i_lim_ic,
    input  logic [WIDTH-1:0] i_lim_oc,
    output logic [WIDTH-1:0] o_row,
    output logic [WIDTH-1:0] o_ic,
    output logic [WIDTH-1:0] o_oc,
    output logic             o_last_ic,
    output logic             o_last
  );

  logic [WIDTH-1:0] r_row;
  logic [WIDTH-1:0] r_ic;
  logic [WIDTH-1:0] r_oc;
  logic             w_last_row;
  logic             w_last_ic;
  logic             w_last_oc;
  logic             w_last;

  assign w_last_row = (r_row == i_lim_row);
  assign w_last_ic  = (r_ic  == i_lim_ic);
  assign w_last_oc  = (r_oc  == i_lim_oc);
  assign w_last     = w_last_row && w_last_ic && w_last_oc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_row <= '0;
      r_ic  <= '0;
      r_oc  <= '0;
    end else if (i_en && !w_last) begin
      // Comparisons use ==, so a limit of all-ones never increments past it.
      if (!w_last_row) begin
        r_row <= r_row + WIDTH'(1);
      end else begin
        r_row <= '0;
        if (!w_last_ic) begin
          r_ic <= r_ic + WIDTH'(1);
        end else begin
          r_ic <= '0;
          r_oc <= r_oc + WIDTH'(1);
        end
      end
    end
  end

  assign o_row     = r_row;
  assign o_ic      = r_ic;
  assign o_oc      = r_oc;
  assign o_last_ic = w_last_ic;
  assign o_last    = w_last;

endmodule

// File: rtl/pu_layer_sequencer.sv
// pu_layer_sequencer
//   Layer-level controller for the PU convolution datapath. Reads one config
//   word per layer, latches it for the PE array, issues one row command per
//   (oc, ic, row) over valid/ready, waits for the write path to drain, then
//   moves to the next layer. Pulses done after the final layer.
//   Ports:
//     clk, reset                 clock, synchronous active-low reset
//     start, num_layers          job start (IDLE only), layer count minus one
//     cfg_addr, cfg_data         config ROM port, 1-cycle read latency
//     layer_cfg, layer_start     latched layer word and its update pulse
//     cmd_valid, cmd_ready       row command handshake
//     cmd_oc/ic/row              command indices
//     cmd_last_ic, cmd_last      end of accumulation / end of layer
//     drain_done                 write path finished the layer
//     state, busy, done, err     status
module pu_layer_sequencer
  import pu_cfg_pkg::*;
  #(
    parameter  int unsigned LAYER_PARAM_WIDTH = PU_LAYER_PARAM_WIDTH,
    parameter  int unsigned PAD_WIDTH         = PU_PAD_WIDTH,
    parameter  int unsigned TID_WIDTH         = PU_TID_WIDTH,
    parameter  int unsigned CFG_ADDR_W        = PU_CFG_ADDR_W,
    localparam int unsigned CFG_WIDTH         = cfg_width(LAYER_PARAM_WIDTH, PAD_WIDTH, TID_WIDTH)
  )
  (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CFG_ADDR_W-1:0]        num_layers,
    output logic [CFG_ADDR_W-1:0]        cfg_addr,
    input  logic [CFG_WIDTH-1:0]         cfg_data,
    output logic [CFG_WIDTH-1:0]         layer_cfg,
    output logic                         layer_start,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [LAYER_PARAM_WIDTH-1:0] cmd_oc,
    output logic [LAYER_PARAM_WIDTH-1:0] cmd_ic,
    output logic [LAYER_PARAM_WIDTH-1:0] cmd_row,
    output logic                         cmd_last_ic,
    output logic                         cmd_last,
    input  logic                         drain_done,
    output logic [2:0]                   state,
    output logic                         busy,
    output logic                         done,
    output logic                         err
  );

  localparam int unsigned LPW     = LAYER_PARAM_WIDTH;
  localparam int unsigned OHW     = LPW + 2;
  localparam int unsigned KH_LSB  = dim_lsb(FLD_KH, LPW);
  localparam int unsigned OC_LSB  = dim_lsb(FLD_OC, LPW);
  localparam int unsigned IH_LSB  = dim_lsb(FLD_IH, LPW);
  localparam int unsigned IC_LSB  = dim_lsb(FLD_IC, LPW);
  localparam int unsigned SKP_LSB = skip_lsb(LPW);
  localparam int unsigned PAD_LSB = pad_lsb(LPW);

  logic [2:0]            r_state;
  logic [CFG_ADDR_W-1:0] r_num_layers;
  logic [CFG_ADDR_W-1:0] r_cfg_addr;
  logic [CFG_WIDTH-1:0]  r_layer_cfg;
  logic                  r_layer_start;
  logic                  r_done;
  logic                  r_err;
  logic [LPW-1:0]        r_lim_row;
  logic [LPW-1:0]        r_lim_ic;
  logic [LPW-1:0]        r_lim_oc;

  logic [LPW-1:0]        w_kh;
  logic [LPW-1:0]        w_ih;
  logic [LPW-1:0]        w_ic;
  logic [LPW-1:0]        w_oc;
  logic [PAD_WIDTH-1:0]  w_pad;
  logic                  w_skip;
  logic signed [OHW-1:0] w_oh;
  logic [LPW-1:0]        w_oh_lim;
  logic                  w_issue;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_cnt_last_ic;
  logic                  w_cnt_last;
  logic                  w_last_layer;
  logic [LPW-1:0]        w_row;
  logic [LPW-1:0]        w_ic_idx;
  logic [LPW-1:0]        w_oc_idx;

  assign w_kh   = cfg_data[KH_LSB +: LPW];
  assign w_ih   = cfg_data[IH_LSB +: LPW];
  assign w_ic   = cfg_data[IC_LSB +: LPW];
  assign w_oc   = cfg_data[OC_LSB +: LPW];
  assign w_pad  = cfg_data[PAD_LSB +: PAD_WIDTH];
  assign w_skip = cfg_data[SKP_LSB];

  // Minus-one encoded output rows: ih + 2*pad - kh. Two extra bits hold the
  // sign and the carry from padding.
  assign w_oh = $signed({2'b00, w_ih})
              + $signed({{(OHW - PAD_WIDTH - 1){1'b0}}, w_pad, 1'b0})
              - $signed({2'b00, w_kh});

  // Heavy padding can push oh past the row field; clamp to the field maximum.
  assign w_oh_lim = w_oh[LPW] ? '1 : w_oh[LPW-1:0];

  assign w_issue      = (r_state == ST_ISSUE);
  assign w_cnt_clr    = (r_state == ST_LOAD);
  assign w_cnt_en     = w_issue && cmd_ready;
  assign w_last_layer = (r_cfg_addr == r_num_layers);

  pu_loop_counter #(
    .WIDTH (LPW)
  ) u_loop_counter (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .i_lim_row (r_lim_row),
    .i_lim_ic  (r_lim_ic),
    .i_lim_oc  (r_lim_oc),
    .o_row     (w_row),
    .o_ic      (w_ic_idx),
    .o_oc      (w_oc_idx),
    .o_last_ic (w_cnt_last_ic),
    .o_last    (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_num_layers  <= '0;
      r_cfg_addr    <= '0;
      r_layer_cfg   <= '0;
      r_layer_start <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_lim_row     <= '0;
      r_lim_ic      <= '0;
      r_lim_oc      <= '0;
    end else begin
      r_layer_start <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_layers <= num_layers;
            r_cfg_addr   <= '0;
            r_err        <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_layer_cfg   <= cfg_data;
          r_layer_start <= 1'b1;
          r_lim_row     <= w_oh_lim;
          r_lim_ic      <= w_ic;
          r_lim_oc      <= w_oc;
          if (w_oh[OHW-1]) begin
            // Impossible geometry: flag it and go straight to end-of-layer.
            r_err <= 1'b1;
            if (w_last_layer) begin
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_cfg_addr <= r_cfg_addr + CFG_ADDR_W'(1);
              r_state    <= ST_FETCH;
            end
          end else if (w_skip) begin
            r_state <= ST_DRAIN;
          end else begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready && w_cnt_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            if (w_last_layer) begin
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_cfg_addr <= r_cfg_addr + CFG_ADDR_W'(1);
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // Placed after the case so a stray drain_done wins over a start clear.
      if (drain_done && (r_state != ST_DRAIN)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cfg_addr    = r_cfg_addr;
  assign layer_cfg   = r_layer_cfg;
  assign layer_start = r_layer_start;
  assign cmd_valid   = w_issue;
  assign cmd_oc      = w_oc_idx;
  assign cmd_ic      = w_ic_idx;
  assign cmd_row     = w_row;
  // Counter limits reset to zero, so the raw last flags read 1 when idle.
  assign cmd_last_ic = w_issue && w_cnt_last_ic;
  assign cmd_last    = w_issue && w_cnt_last;
  assign state       = r_state;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_pu_layer_sequencer.sv
module tb_pu_layer_sequencer;

  localparam int unsigned LPW  = 10;
  localparam int unsigned PADW = 3;
  localparam int unsigned TIDW = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned CW   = TIDW + PADW + 1 + 7 * LPW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   num_layers = '0;
  logic [AW-1:0]   cfg_addr;
  logic [CW-1:0]   cfg_data = '0;
  logic [CW-1:0]   layer_cfg;
  logic            layer_start;
  logic            cmd_valid;
  logic            cmd_ready = 1'b0;
  logic [LPW-1:0]  cmd_oc;
  logic [LPW-1:0]  cmd_ic;
  logic [LPW-1:0]  cmd_row;
  logic            cmd_last_ic;
  logic            cmd_last;
  logic            drain_done = 1'b0;
  logic [2:0]      state;
  logic            busy;
  logic            done;
  logic            err;

  pu_layer_sequencer #(
    .LAYER_PARAM_WIDTH (LPW),
    .PAD_WIDTH         (PADW),
    .TID_WIDTH         (TIDW),
    .CFG_ADDR_W        (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_layers  (num_layers),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .layer_cfg   (layer_cfg),
    .layer_start (layer_start),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_oc      (cmd_oc),
    .cmd_ic      (cmd_ic),
    .cmd_row     (cmd_row),
    .cmd_last_ic (cmd_last_ic),
    .cmd_last    (cmd_last),
    .drain_done  (drain_done),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Config ROM with one cycle of read latency.
  logic [CW-1:0] rom [16];
  always @(posedge clk) cfg_data <= rom[cfg_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Packing written out field by field: {max_threads, pad, skip, endrow_iw, ic, ih, iw, oc, kh, kw}.
  function automatic logic [CW-1:0] mk_cfg(input int kh, input int ih, input int pad,
                                           input int ic, input int oc, input bit skip);
    return {16'd7, 3'(pad), skip, 10'(ih + 2), 10'(ic), 10'(ih), 10'(ih + 5),
            10'(oc), 10'(kh), 10'(kh + 1)};
  endfunction

  typedef struct {
    int oc;
    int ic;
    int row;
    bit lic;
    bit last;
  } cmd_t;

  // ---------------- monitor ----------------
  cmd_t            got[$];
  int              trace[$];
  int              ls_addr[$];
  logic [CW-1:0]   ls_cfg[$];
  int              n_done = 0;
  int              n_drain_cyc = 0;
  int              n_issue_cyc = 0;
  int              n_unstable = 0;
  int              last_state = 0;
  bit              hold_pending = 1'b0;
  logic [3*LPW+1:0] held = '0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready)
      got.push_back('{int'(cmd_oc), int'(cmd_ic), int'(cmd_row), cmd_last_ic, cmd_last});
    if (layer_start) begin
      ls_addr.push_back(int'(cfg_addr));
      ls_cfg.push_back(layer_cfg);
    end
    if (done) n_done++;
    if (state == 3'd4) n_drain_cyc++;
    if (state == 3'd3) n_issue_cyc++;
    if (int'(state) != last_state) begin
      trace.push_back(int'(state));
      last_state = int'(state);
    end
    if (hold_pending && cmd_valid && ({cmd_oc, cmd_ic, cmd_row, cmd_last_ic, cmd_last} != held))
      n_unstable++;
    hold_pending = cmd_valid && !cmd_ready;
    held = {cmd_oc, cmd_ic, cmd_row, cmd_last_ic, cmd_last};
  end

  task automatic clr_mon();
    got.delete();
    trace.delete();
    ls_addr.delete();
    ls_cfg.delete();
    n_done = 0;
    n_drain_cyc = 0;
    n_issue_cyc = 0;
    n_unstable = 0;
    last_state = int'(state);
    hold_pending = 1'b0;
  endtask

  task automatic start_job();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives cmd_ready, answers each DRAIN after 3 waiting cycles, stops on done.
  task automatic run_job(input int budget, input bit rnd, output bit ok, output int lat);
    int cyc = 0;
    int dwait = 0;
    int drain_cyc = -100;
    ok = 1'b0;
    lat = -1;
    while (cyc < budget) begin
      cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drain_done = 1'b0;
      if (state == 3'd4) begin
        if (dwait == 3) begin
          drain_done = 1'b1;
          drain_cyc = cyc;
        end else begin
          dwait++;
        end
      end else begin
        dwait = 0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ok = 1'b1;
        lat = cyc - drain_cyc;
        break;
      end
    end
    drain_done = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (state != 3'd3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(state), 3);
  endtask

  // Counts deviations of the recorded commands from the (oc, ic, row) nest.
  task automatic check_seq(input string name, input int base, input int oh, input int ic, input int oc);
    int k = base;
    int bad = 0;
    for (int o = 0; o <= oc; o++)
      for (int i = 0; i <= ic; i++)
        for (int r = 0; r <= oh; r++) begin
          if (k >= got.size()) bad++;
          else if (got[k].oc != o || got[k].ic != i || got[k].row != r ||
                   got[k].lic != (i == ic) ||
                   got[k].last != (o == oc && i == ic && r == oh)) bad++;
          k++;
        end
    check(name, bad, 0);
  endtask

  task automatic check_trace(input string name, input int exp_tr[$]);
    int bad = 0;
    if (trace.size() != exp_tr.size()) bad = 100 + trace.size();
    else
      for (int i = 0; i < exp_tr.size(); i++)
        if (trace[i] != exp_tr[i]) bad++;
    check(name, bad, 0);
  endtask

  typedef struct {
    int kh;
    int ih;
    int pad;
    int ic;
    int oc;
    bit skip;
    int oh;
    int ncmd;
    bit err;
    bit drains;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    int lat;
    int exp_tr[$];

    //          kh    ih    pad ic    oc skip  oh  ncmd  err   drains
    vecs[0] = '{2,    4,    1,  1,    0, 1'b0, 4,  10,   1'b0, 1'b1};
    vecs[1] = '{0,    2,    0,  0,    2, 1'b0, 2,  9,    1'b0, 1'b1};
    vecs[2] = '{3,    3,    0,  2,    1, 1'b0, 0,  6,    1'b0, 1'b1};
    vecs[3] = '{4,    1,    0,  0,    0, 1'b0, -3, 0,    1'b1, 1'b0};
    vecs[4] = '{1,    3,    0,  0,    0, 1'b1, 2,  0,    1'b0, 1'b1};
    vecs[5] = '{0,    0,    7,  0,    0, 1'b0, 14, 15,   1'b0, 1'b1};
    vecs[6] = '{1023, 1023, 0,  1023, 0, 1'b0, 0,  1024, 1'b0, 1'b1};
    vecs[7] = '{0,    5,    0,  1,    1, 1'b0, 5,  24,   1'b0, 1'b1};

    for (int i = 0; i < 16; i++) rom[i] = '0;

    // ---- reset state ----
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_cfg_addr", int'(cfg_addr), 0);
    check("rst_layer_cfg_zero", int'(layer_cfg == '0), 1);
    check("rst_flags", int'({cmd_valid, cmd_last, cmd_last_ic, layer_start, done, err, busy}), 0);
    check("rst_cmd_idx", int'({cmd_oc, cmd_ic, cmd_row} == '0), 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- table: single-layer geometries ----
    for (int v = 0; v < 8; v++) begin
      rom[0] = mk_cfg(vecs[v].kh, vecs[v].ih, vecs[v].pad, vecs[v].ic, vecs[v].oc, vecs[v].skip);
      num_layers = '0;
      clr_mon();
      start_job();
      run_job(3000, 1'b0, ok, lat);
      check($sformatf("v%0d_done", v), int'(ok), 1);
      check($sformatf("v%0d_done_pulses", v), n_done, 1);
      check($sformatf("v%0d_ncmd", v), got.size(), vecs[v].ncmd);
      if (vecs[v].ncmd > 0)
        check_seq($sformatf("v%0d_seq", v), 0, vecs[v].oh, vecs[v].ic, vecs[v].oc);
      check($sformatf("v%0d_issue_cycles", v), n_issue_cyc, vecs[v].ncmd);
      check($sformatf("v%0d_err", v), int'(err), int'(vecs[v].err));
      check($sformatf("v%0d_drain_cycles", v), n_drain_cyc, vecs[v].drains ? 4 : 0);
      if (vecs[v].drains)
        check($sformatf("v%0d_done_latency", v), lat, 1);
      check($sformatf("v%0d_layer_starts", v), ls_cfg.size(), 1);
      check($sformatf("v%0d_layer_cfg", v), int'(ls_cfg.size() == 1 && ls_cfg[0] == rom[0]), 1);
      check($sformatf("v%0d_idle", v), int'({busy, state}), 0);
    end

    // ---- backpressure ----
    rom[0] = mk_cfg(2, 4, 1, 1, 0, 1'b0);
    num_layers = '0;
    clr_mon();
    start_job();
    run_job(3000, 1'b1, ok, lat);
    check("bp_done", int'(ok), 1);
    check("bp_ncmd", got.size(), 10);
    check_seq("bp_seq", 0, 4, 1, 0);
    check("bp_stable", n_unstable, 0);

    // ---- three layers ----
    rom[0] = mk_cfg(2, 4, 1, 1, 0, 1'b0);
    rom[1] = mk_cfg(3, 3, 0, 2, 1, 1'b0);
    rom[2] = mk_cfg(0, 2, 0, 0, 2, 1'b0);
    num_layers = 4'd2;
    clr_mon();
    start_job();
    run_job(3000, 1'b0, ok, lat);
    check("ml_done", int'(ok), 1);
    check("ml_done_pulses", n_done, 1);
    check("ml_ncmd", got.size(), 25);
    check_seq("ml_seq_l0", 0, 4, 1, 0);
    check_seq("ml_seq_l1", 10, 0, 2, 1);
    check_seq("ml_seq_l2", 16, 2, 0, 2);
    check("ml_layer_starts", ls_addr.size(), 3);
    check("ml_addrs", int'(ls_addr.size() == 3 && ls_addr[0] == 0 && ls_addr[1] == 1 && ls_addr[2] == 2), 1);
    exp_tr = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 5, 0};
    check_trace("ml_trace", exp_tr);

    // ---- invalid geometry, then skip, then a normal layer ----
    rom[0] = mk_cfg(4, 1, 0, 0, 0, 1'b0);
    rom[1] = mk_cfg(1, 3, 0, 0, 0, 1'b1);
    rom[2] = mk_cfg(2, 4, 1, 1, 0, 1'b0);
    num_layers = 4'd2;
    clr_mon();
    start_job();
    run_job(3000, 1'b0, ok, lat);
    check("inv_done", int'(ok), 1);
    check("inv_err", int'(err), 1);
    check("inv_ncmd", got.size(), 10);
    check_seq("inv_seq", 0, 4, 1, 0);
    exp_tr = '{1, 2, 1, 2, 4, 1, 2, 3, 4, 5, 0};
    check_trace("inv_trace", exp_tr);

    // Accepted start clears the sticky error.
    rom[0] = mk_cfg(2, 4, 1, 1, 0, 1'b0);
    num_layers = '0;
    clr_mon();
    start_job();
    check("errclr_on_start", int'({err, state}), 1);
    run_job(3000, 1'b0, ok, lat);
    check("errclr_done", int'(ok), 1);

    // ---- reset mid-ISSUE ----
    clr_mon();
    start_job();
    cmd_ready = 1'b0;
    wait_issue("rst_reach_issue");
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    check("rst_pre_handshakes", got.size(), 3);
    check("rst_pre_row", int'(cmd_row), 3);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_valid_busy", int'({cmd_valid, busy}), 0);
    check("rst_mid_cmd_idx", int'({cmd_oc, cmd_ic, cmd_row} == '0), 1);
    check("rst_mid_addr", int'(cfg_addr), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    clr_mon();
    start_job();
    run_job(3000, 1'b0, ok, lat);
    check("rst_rerun_done", int'(ok), 1);
    check("rst_rerun_ncmd", got.size(), 10);
    check_seq("rst_rerun_seq", 0, 4, 1, 0);
    check("rst_rerun_addr", int'(ls_addr.size() == 1 && ls_addr[0] == 0), 1);

    // ---- protocol: start and drain_done during ISSUE ----
    clr_mon();
    start_job();
    cmd_ready = 1'b0;
    wait_issue("proto_reach_issue");
    start = 1'b1;
    num_layers = 4'd5;
    drain_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_layers = '0;
    drain_done = 1'b0;
    check("proto_state", int'(state), 3);
    check("proto_err", int'(err), 1);
    check("proto_cmd_held", int'({cmd_valid, cmd_oc, cmd_ic, cmd_row}), 1 << (3 * LPW));
    run_job(3000, 1'b0, ok, lat);
    check("proto_done", int'(ok), 1);
    check("proto_ncmd", got.size(), 10);
    check("proto_layers", ls_addr.size(), 1);
    check("proto_err_sticky", int'(err), 1);
    exp_tr = '{1, 2, 3, 4, 5, 0};
    check_trace("proto_trace", exp_tr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog: a hang still reports before stopping.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pu_layer_sequencer.md
Name: pu_layer_sequencer

Overview:
- Layer-level controller for the PU convolution datapath.
- Walks a configuration ROM one layer at a time and latches each layer's parameters for the PE array.
- Issues one row command per (output channel, input channel, output row) over a valid/ready handshake.
- After each layer's last command, waits for the output write path to drain, then advances. Pulses done after the final layer.

Parameters:
- LAYER_PARAM_WIDTH, 10, width of each minus-one-encoded layer dimension field.
- PAD_WIDTH, 3, padding field width.
- TID_WIDTH, 16, max_threads field width.
- CFG_ADDR_W, 4, config ROM address width (up to 16 layers).
- CFG_WIDTH, TID_WIDTH+PAD_WIDTH+1+7*LAYER_PARAM_WIDTH (90), config word width; derived, do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  active-low synchronous reset.
- start  in  1  level; sampled only in IDLE.
- num_layers  in  CFG_ADDR_W  layer count minus one; captured on start.
- cfg_addr  out  CFG_ADDR_W  ROM address.
- cfg_data  in  CFG_WIDTH  ROM word, valid 1 cycle after cfg_addr. Packing MSB to LSB: {max_threads, pad, skip, endrow_iw, ic, ih, iw, oc, kh, kw}.
- layer_cfg  out  CFG_WIDTH  registered copy of the current layer word.
- layer_start  out  1  one-cycle pulse when layer_cfg updates.
- cmd_valid  out  1  row command valid.
- cmd_ready  in  1  PU accepts the command.
- cmd_oc, cmd_ic, cmd_row  out  LAYER_PARAM_WIDTH each  command indices.
- cmd_last_ic  out  1  cmd_ic equals the layer's ic field (accumulation ends).
- cmd_last  out  1  last command of the layer.
- drain_done  in  1  pulse from write path: all layer outputs written.
- state  out  3  FSM state, for debug and bench.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final layer drains.
- err  out  1  sticky; cleared on accepted start.

Behaviour:
- Reset (reset==0 at a clk edge) gives state=IDLE and zeroes cfg_addr, layer_cfg, all cmd_* outputs, layer_start, done, err and all counters. This applies from any state; an in-flight command is dropped and the ROM is not re-read.
- State encoding: IDLE=0, FETCH=1, LOAD=2, ISSUE=3, DRAIN=4, FINISH=5.
- IDLE: start=1 captures num_layers, sets cfg_addr=0, clears err, goes to FETCH.
- FETCH (1 cycle): wait for ROM latency, go to LOAD.
- LOAD (1 cycle): register cfg_data into layer_cfg, pulse layer_start, clear row/ic/oc counters.
  - Compute oh = ih + 2*pad - kh (minus-one encoded output rows), signed, LAYER_PARAM_WIDTH+2 bits.
  - If oh<0: set err and skip to end-of-layer handling; no commands are issued and DRAIN is not entered.
  - Else if skip=1: go to DRAIN.
  - Else: go to ISSUE.
- ISSUE: cmd_valid=1 while counters are in range; command fields hold stable until cmd_valid&&cmd_ready.
  - Counter order: row innermost (0..oh), then ic (0..ic), then oc (0..oc).
  - Next command is presented the cycle after a handshake; zero bubbles when cmd_ready stays high.
  - Accepting the command with cmd_last=1 drops cmd_valid the next cycle and moves to DRAIN.
- DRAIN: wait for drain_done.
  - drain_done outside DRAIN is ignored and sets err.
- End of layer: if layer index == num_layers, go to FINISH; else increment cfg_addr and go to FETCH.
- FINISH: pulse done for 1 cycle, return to IDLE.
- start while busy is ignored.
- Commands per layer = (oc+1)*(ic+1)*(oh+1). Per-layer overhead is 2 cycles (FETCH+LOAD) plus the drain wait.
- Counters do not wrap past field maxima. Fields equal to 1023 are legal.

Decomposition:
- Shared package pu_cfg_pkg holds:
  - FSM state localparams.
  - Config field widths and bit offsets, plus an unpack helper for the config word.
  - CFG_WIDTH derivation.
- One sub-module, pu_loop_counter: nested row/ic/oc counter with enable, limits, last flags and clear. Reused later by the pooling controller.

Test Plan:
- Single layer: num_layers=0, kh=kw=2, ih=iw=4, pad=1, ic=1, oc=0, cmd_ready=1 -> oh=4; 10 commands (ic0 rows0..4, ic1 rows0..4) back-to-back; cmd_last_ic on the last 5; cmd_last on (0,1,4); done 1 cycle after drain_done.
- Backpressure: same config, cmd_ready random 50% -> exactly 10 handshakes in identical order; fields stable while valid && !ready.
- Three layers, num_layers=2 -> cfg_addr 0,1,2; three layer_start pulses; a single done; state 1->2->3->4 per layer.
- Invalid geometry: ih=1, kh=4, pad=0 -> err=1, zero commands, next layer proceeds; skip=1 layer -> zero commands, waits for drain_done.
- Reset mid-ISSUE after 3 handshakes -> next cycle state=0, cmd_valid=0, busy=0. A new start re-fetches from cfg_addr=0 and issues from (0,0,0).
- Protocol: start asserted during ISSUE has no effect; drain_done pulse during ISSUE sets err without advancing state.
